logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

- Shares one WIDTH-bit bitwise logic unit between NREQ requesters.
- Logic unit ops: AND, OR, NOT, NAND, NOR, XOR, XNOR.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- The controller fetches operands, runs the selected gate op, and presents one registered result with the winner's ID on a response handshake.
- It is the scheduling front end that lets several datapath clients share the gate array.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ)
- WIDTH, 8, operand/result width in bits

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  request pending, one bit per requester
- req_ready  output  NREQ  one-hot accept, combinational
- req_op  input  3*NREQ  op code, slice i belongs to requester i
- req_a  input  WIDTH*NREQ  operand a, slice i
- req_b  input  WIDTH*NREQ  operand b, slice i
- rsp_valid  output  1  result available
- rsp_ready  input  1  downstream accepts result
- rsp_id  output  IDW  index of requester that owns the result
- rsp_data  output  WIDTH  result
- busy  output  1  high whenever state != IDLE
- rsp_err  output  1  illegal op flag (only with LOGIC_ARB_ERR_EN)

## Operation
Op encoding:
- 0 AND (a&b), 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved (see Configuration).

FSM states are IDLE, EXEC and RESP.
- IDLE: if any req_valid, the winner is the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready[winner]=1 this cycle, all other bits 0.
  - Handshake completes on the same edge. op/a/b/winner are latched, ptr <= winner+1 (wraps NREQ-1 -> 0), and the FSM goes to EXEC.
  - With no req_valid: req_ready=0 and the FSM stays in IDLE.
- EXEC: computes the op on the latched operands. rsp_data, rsp_id and rsp_err are registered. rsp_valid <= 1. The FSM goes to RESP.
- RESP: rsp_valid, rsp_data, rsp_id and rsp_err stay stable until rsp_valid&rsp_ready. On that edge: rsp_valid <= 0 and the FSM goes to IDLE. req_ready=0 throughout.
- req_ready is 0 in EXEC and RESP. Requesters must hold req_valid, req_op, req_a and req_b stable until they see their ready bit.
- Deasserting req_valid before grant is allowed. That requester then simply loses eligibility.
- The ptr update guarantees fairness: a continuously requesting client waits at most NREQ-1 other transactions.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, ptr=0, state=IDLE.
- Reset mid-operation discards the in-flight transaction with no response. The cycle after rst deasserts is IDLE.
- Latency:
  - Accept edge at cycle T; rsp_valid is high from T+2.
  - With rsp_ready held high, the response completes at T+2 and the next accept can occur at T+3.
- Peak throughput is 1 op / 3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely, and no new request is accepted.
- Simultaneous requests: only one wins per IDLE cycle. The others keep req_valid high and win in later rounds in ptr order.
- Width rule: every op is bitwise over all WIDTH bits, with no carries and no truncation.

## Configuration
LOGIC_ARB_ERR_EN selects how op code 7 is handled.
- Defined:
  - The rsp_err port exists.
  - Op 7 produces rsp_data=0 and rsp_err=1 with the normal response handshake and timing.
  - rsp_err=0 for ops 0..6.
- Undefined:
  - The rsp_err port is absent.
  - Op 7 is BUF: rsp_data=a, no error indication.

## Test plan
- Reset/idle: hold rst 2 cycles with req_valid=4'b1111 -> all outputs 0. First accept goes to requester 0 on the first cycle after release.
- Op sweep: requester 2 only, WIDTH=8, a=8'hC5, b=8'h3A, ops 0..6 -> rsp_data = 00, FF, 3A, FF, 00, FF, 00; rsp_id=2; rsp_valid at T+2.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0. Then req_valid=4'b1010 -> order continues 1,3,1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready=0, busy=1. Raising rsp_ready completes the transfer, and the next accept follows 1 cycle later.
- Op 7, a=8'h5A -> with LOGIC_ARB_ERR_EN: rsp_data=00, rsp_err=1. Without it: rsp_data=5A.
- Reset in EXEC -> no rsp_valid ever appears for that transaction, and ptr returns to 0.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between NREQ requesters, the logic_unit_arbiter and its response sink.
// rsp_err is present only when LOGIC_ARB_ERR_EN is defined.
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
`ifdef LOGIC_ARB_ERR_EN
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin front end sharing one WIDTH-bit bitwise logic unit between NREQ requesters.
// LOGIC_ARB_ERR_EN: op 7 flags rsp_err with zero data; otherwise op 7 passes operand a through.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NOT, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_RSVD
  } op_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   sel_id;
  op_t              sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   ptr_next;
  logic [IDW:0]     cand;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] gate_out;

`ifdef LOGIC_ARB_ERR_EN
  logic             gate_err;
  logic             rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`endif

  // Search upward from ptr, wrapping modulo NREQ; cand is one bit wider so the wrap never overflows.
  // NOTE: every variable driven here gets a default before the loop, so no latch can be inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found && !rst) grant[winner] = 1'b1;
  end

  assign ptr_next      = (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state != IDLE);

  always_comb begin
    gate_out = '0;
`ifdef LOGIC_ARB_ERR_EN
    gate_err = 1'b0;
`endif
    case (sel_op)
      OP_AND:  gate_out = sel_a & sel_b;
      OP_OR:   gate_out = sel_a | sel_b;
      OP_NOT:  gate_out = ~sel_a;
      OP_NAND: gate_out = ~(sel_a & sel_b);
      OP_NOR:  gate_out = ~(sel_a | sel_b);
      OP_XOR:  gate_out = sel_a ^ sel_b;
      OP_XNOR: gate_out = ~(sel_a ^ sel_b);
      OP_RSVD: begin
`ifdef LOGIC_ARB_ERR_EN
        gate_err = 1'b1;
`else
        gate_out = sel_a;
`endif
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the latched operands are reset along with the outputs so a discarded transaction leaves no trace.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      sel_id      <= '0;
      sel_op      <= OP_AND;
      sel_a       <= '0;
      sel_b       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef LOGIC_ARB_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel_id <= winner;
            sel_op <= op_t'(bus.req_op[3*int'(winner) +: 3]);
            sel_a  <= bus.req_a[WIDTH*int'(winner) +: WIDTH];
            sel_b  <= bus.req_b[WIDTH*int'(winner) +: WIDTH];
            ptr    <= ptr_next;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= gate_out;
          rsp_id_q    <= sel_id;
`ifdef LOGIC_ARB_ERR_EN
          rsp_err_q   <= gate_err;
`endif
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model. Honours LOGIC_ARB_ERR_EN the same way as the design.
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  logic_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: arbiter is either free or owns one transaction of a given age.
  int         m_ptr  = 0;
  bit         m_idle = 1'b1;
  int         m_age  = 0;
  int         exp_id;
  logic [7:0] exp_data;
  bit         exp_err;
  bit         rst_prev = 1'b0;

  int         dut_gnt;
  int         grant_log[$];
  int         rsp_count = 0;
  int         last_id;
  int         last_data;
  int         last_err;

  int              refill_mode = 0;   // 0 none, 1 keep masked requesters busy, 2 random traffic
  logic [NREQ-1:0] refill_mask = '1;

  function automatic logic [7:0] ref_gate(int op, logic [7:0] a, logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
`ifdef LOGIC_ARB_ERR_EN
      default: return 8'h00;
`else
      default: return a;
`endif
    endcase
  endfunction

  function automatic bit ref_err(int op);
`ifdef LOGIC_ARB_ERR_EN
    return op == 7;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NREQ; k++)
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic new_req(int i, bit valid);
    bus.req_valid[i]             = valid;
    bus.req_op[3*i +: 3]         = 3'($urandom_range(0, 7));
    bus.req_a[WIDTH*i +: WIDTH]  = WIDTH'($urandom);
    bus.req_b[WIDTH*i +: WIDTH]  = WIDTH'($urandom);
  endtask

  task automatic set_req(int i, int op, logic [7:0] a, logic [7:0] b);
    bus.req_valid[i]             = 1'b1;
    bus.req_op[3*i +: 3]         = 3'(op);
    bus.req_a[WIDTH*i +: WIDTH]  = a;
    bus.req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  // One clock: check at the falling edge, then apply stimulus just after the rising edge.
  task automatic step();
    int w;
    @(negedge clk);
    dut_gnt = -1;
    if (rst) begin
      check("rst_req_ready", bus.req_ready, 0);
      if (rst_prev) begin
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_busy", busy, 0);
`ifdef LOGIC_ARB_ERR_EN
        check("rst_rsp_err", bus.rsp_err, 0);
`endif
      end
      rst_prev = 1'b1;
      m_idle   = 1'b1;
      m_ptr    = 0;
      m_age    = 0;
    end else begin
      rst_prev = 1'b0;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_gnt = i;
      if (dut_gnt >= 0) grant_log.push_back(dut_gnt);
      if (m_idle) begin
        w = model_winner();
        check("req_ready", bus.req_ready, (w < 0) ? 0 : (1 << w));
        check("idle_rsp_valid", bus.rsp_valid, 0);
        check("idle_busy", busy, 0);
        if (w >= 0) begin
          exp_id   = w;
          exp_data = ref_gate(int'(bus.req_op[3*w +: 3]), bus.req_a[WIDTH*w +: WIDTH],
                              bus.req_b[WIDTH*w +: WIDTH]);
          exp_err  = ref_err(int'(bus.req_op[3*w +: 3]));
          m_ptr    = (w + 1) % NREQ;
          m_idle   = 1'b0;
          m_age    = 0;
        end
      end else begin
        m_age++;
        check("busy_req_ready", bus.req_ready, 0);
        check("busy", busy, 1);
        if (m_age == 1) begin
          check("exec_rsp_valid", bus.rsp_valid, 0);
        end else begin
          check("rsp_valid", bus.rsp_valid, 1);
          check("rsp_id", bus.rsp_id, exp_id);
          check("rsp_data", bus.rsp_data, exp_data);
`ifdef LOGIC_ARB_ERR_EN
          check("rsp_err", bus.rsp_err, exp_err);
`endif
          if (bus.rsp_ready) begin
            m_idle    = 1'b1;
            last_id   = bus.rsp_id;
            last_data = bus.rsp_data;
`ifdef LOGIC_ARB_ERR_EN
            last_err  = bus.rsp_err;
`else
            last_err  = 0;
`endif
            rsp_count++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (refill_mode != 0 && dut_gnt >= 0) begin
      if (refill_mode == 1) new_req(dut_gnt, refill_mask[dut_gnt]);
      else new_req(dut_gnt, $urandom_range(0, 3) != 0);
    end
    if (refill_mode == 2) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (i != dut_gnt) begin
          if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) new_req(i, 1'b1);
          else if (bus.req_valid[i] && $urandom_range(0, 31) == 0) bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_grants(int n, int budget);
    int target = grant_log.size() + n;
    for (int c = 0; c < budget && grant_log.size() < target; c++) step();
    if (grant_log.size() < target) check("grant_timeout", grant_log.size(), target);
  endtask

  task automatic wait_rsp(int n, int budget);
    int target = rsp_count + n;
    for (int c = 0; c < budget && rsp_count < target; c++) step();
    if (rsp_count < target) check("rsp_timeout", rsp_count, target);
  endtask

  task automatic wait_idle(int budget);
    for (int c = 0; c < budget && !m_idle; c++) step();
    if (!m_idle) check("idle_timeout", m_idle, 1);
  endtask

  function automatic int log_at(int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rr_a[5] = '{0, 1, 2, 3, 0};
    int         rr_b[3] = '{1, 3, 1};
    logic [7:0] sweep_exp[7] = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset held two cycles with every requester pending, then round-robin over all four.
    refill_mode = 1;
    refill_mask = 4'b1111;
    for (int i = 0; i < NREQ; i++) new_req(i, 1'b1);
    step();
    step();
    rst = 1'b0;
    grant_log.delete();
    step();
    check("first_grant", log_at(0), 0);
    wait_grants(4, 20);
    for (int k = 0; k < 5; k++) check("rr_all", log_at(k), rr_a[k]);

    refill_mask   = 4'b1010;
    bus.req_valid = bus.req_valid & 4'b1010;
    grant_log.delete();
    wait_grants(3, 20);
    for (int k = 0; k < 3; k++) check("rr_1010", log_at(k), rr_b[k]);

    // Op sweep on requester 2.
    refill_mode   = 0;
    bus.req_valid = '0;
    wait_idle(20);
    for (int op = 0; op < 7; op++) begin
      set_req(2, op, 8'hC5, 8'h3A);
      wait_grants(1, 10);
      bus.req_valid[2] = 1'b0;
      wait_rsp(1, 10);
      check("sweep_data", last_data, sweep_exp[op]);
      check("sweep_id", last_id, 2);
    end

    // Backpressure: response held ten cycles while another requester waits.
    bus.rsp_ready = 1'b0;
    set_req(1, 5, 8'h96, 8'h0F);
    set_req(3, 1, 8'h81, 8'h18);
    grant_log.delete();
    wait_grants(1, 10);
    bus.req_valid[3] = 1'b0;
    repeat (12) step();
    check("bp_no_grant", grant_log.size(), 1);
    check("bp_busy", busy, 1);
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("bp_next_grant", grant_log.size(), 2);
    check("bp_order0", log_at(0), 3);
    check("bp_order1", log_at(1), 1);
    bus.req_valid[1] = 1'b0;
    wait_idle(20);

    // Reserved op 7.
    set_req(0, 7, 8'h5A, 8'hC3);
    wait_grants(1, 10);
    bus.req_valid[0] = 1'b0;
    wait_rsp(1, 10);
`ifdef LOGIC_ARB_ERR_EN
    check("op7_data", last_data, 8'h00);
    check("op7_err", last_err, 1);
`else
    check("op7_data", last_data, 8'h5A);
`endif

    // Reset while the transaction is in EXEC.
    set_req(2, 0, 8'hFF, 8'hFF);
    wait_grants(1, 10);
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) new_req(i, 1'b1);
    grant_log.delete();
    step();
    check("rst_exec_grant", log_at(0), 0);
    bus.req_valid = '0;
    wait_rsp(1, 10);
    check("rst_exec_id", last_id, 0);

    // Random traffic with random backpressure.
    refill_mode = 2;
    repeat (900) step();
    refill_mode   = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle(20);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
